// File: rtl/cpu_trace_buffer_if.sv
// Trace buffer bus: CPU sample inputs, capture control and the pop-side read port.
interface cpu_trace_buffer_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = PC_W + INSTR_W + DATA_W;

    logic [PC_W-1:0]    pc_i;
    logic [INSTR_W-1:0] instr_i;
    logic [DATA_W-1:0]  out_i;
    logic               arm_i;
    logic               trig_en_i;
    logic [PC_W-1:0]    trig_pc_i;
    logic [AW-1:0]      post_cnt_i;
    logic               rd_en_i;
    logic [EW-1:0]      rd_data_o;
    logic               rd_valid_o;
    logic               rd_empty_o;
    logic [AW:0]        count_o;
    logic [1:0]         state_o;
    logic               triggered_o;

    modport master (
        output pc_i, instr_i, out_i, arm_i, trig_en_i, trig_pc_i, post_cnt_i, rd_en_i,
        input  rd_data_o, rd_valid_o, rd_empty_o, count_o, state_o, triggered_o
    );

    modport slave (
        input  pc_i, instr_i, out_i, arm_i, trig_en_i, trig_pc_i, post_cnt_i, rd_en_i,
        output rd_data_o, rd_valid_o, rd_empty_o, count_o, state_o, triggered_o
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// CPU trace capture: ring buffer of {pc, instr, out} samples with PC-match
// trigger, post-trigger window, optional change-only capture and oldest-first readout.
module cpu_trace_buffer #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int MODE    = 0
) (
    input logic               clk,
    input logic               rst,
    cpu_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + INSTR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     post_q;
    logic [DATA_W-1:0] prev_out_q;
    logic              first_q;
    logic              trig_q;
    logic [EW-1:0]     rd_data_q;
    logic              rd_valid_q;
    logic [EW-1:0]     mem_q [DEPTH];

    logic          trig_hit;
    logic          qual;
    logic          wr_en;
    logic          rd_pop;
    logic          full;
    logic [EW-1:0] sample;

    // Write/read qualification for this cycle; arm suppresses both.
    always_comb begin
        sample   = {bus.pc_i, bus.instr_i, bus.out_i};
        full     = (count_q == CW'(DEPTH));
        trig_hit = (state_q == S_PRE) && bus.trig_en_i && (bus.pc_i == bus.trig_pc_i);
        qual     = (MODE == 0) || first_q || (bus.out_i != prev_out_q);
        wr_en    = !bus.arm_i && (((state_q == S_PRE) && (qual || trig_hit)) ||
                                  ((state_q == S_POST) && qual));
        rd_pop   = !bus.arm_i && (state_q == S_DONE) && bus.rd_en_i && (count_q != '0);
    end

    // Pointer/occupancy next state; a write into a full ring drops the oldest entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.arm_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (full) rd_ptr_d = rd_ptr_q + 1'b1;
            else      count_d  = count_q + 1'b1;
        end else if (rd_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    // Capture FSM with registered read port and trigger flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_q     <= '0;
            prev_out_q <= '0;
            first_q    <= 1'b0;
            trig_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            prev_out_q <= bus.out_i;
            rd_valid_q <= 1'b0;
            if (bus.arm_i) begin
                state_q <= S_PRE;
                trig_q  <= 1'b0;
                // The field is AW bits wide, so it can never exceed DEPTH-1.
                post_q  <= bus.post_cnt_i;
                first_q <= 1'b1;
            end else begin
                first_q <= 1'b0;
                case (state_q)
                    S_PRE: begin
                        if (trig_hit) begin
                            trig_q  <= 1'b1;
                            state_q <= (post_q == '0) ? S_DONE : S_POST;
                        end
                    end
                    S_POST: begin
                        if (wr_en) begin
                            post_q <= post_q - 1'b1;
                            if (post_q == AW'(1)) state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (rd_pop) begin
                            rd_data_q  <= mem_q[rd_ptr_q];
                            rd_valid_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sample storage; contents after reset are don't-care since count is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= sample;
    end

    assign bus.rd_data_o   = rd_data_q;
    assign bus.rd_valid_o  = rd_valid_q;
    assign bus.rd_empty_o  = (count_q == '0);
    assign bus.count_o     = count_q;
    assign bus.state_o     = state_q;
    assign bus.triggered_o = trig_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: one MODE 0 and one MODE 1 instance, DEPTH 8.
module tb_cpu_trace_buffer;
    localparam int DEPTH = 8;
    localparam int EW    = 96;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cpu_trace_buffer_if #(.PC_W(32), .INSTR_W(32), .DATA_W(32), .DEPTH(DEPTH)) ifa ();
    cpu_trace_buffer_if #(.PC_W(32), .INSTR_W(32), .DATA_W(32), .DEPTH(DEPTH)) ifb ();

    cpu_trace_buffer #(.PC_W(32), .INSTR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MODE(0))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    cpu_trace_buffer #(.PC_W(32), .INSTR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MODE(1))
        u_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] sb_a[$];
    logic [EW-1:0] sb_b[$];

    typedef struct {
        int         idx;
        logic [1:0] st;
        int         cnt;
        logic       trg;
    } vec_t;
    vec_t tv[12];

    function automatic logic [EW-1:0] smp(input int i);
        return {32'(i * 4), 32'hA500_0000 + 32'(i), 32'(i * 3)};
    endfunction

    task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input int i);
        {ifa.pc_i, ifa.instr_i, ifa.out_i} = smp(i);
    endtask

    // Scoreboard model of the ring: keep only the newest DEPTH samples.
    task automatic push_a(input int i);
        sb_a.push_back(smp(i));
        if (sb_a.size() > DEPTH) void'(sb_a.pop_front());
    endtask

    task automatic arm_a(input logic [2:0] pc);
        ifa.arm_i      = 1'b1;
        ifa.post_cnt_i = pc;
        tick;
        ifa.arm_i = 1'b0;
        sb_a.delete();
    endtask

    task automatic pop_all_a(input string nm, input int budget, output int pulses);
        pulses = 0;
        ifa.rd_en_i = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick;
            if (ifa.rd_valid_o) begin
                pulses++;
                if (sb_a.size() > 0) chk(nm, ifa.rd_data_o, sb_a.pop_front());
                else chk({nm, " extra pop"}, ifa.rd_valid_o, 1'b0);
            end
        end
        ifa.rd_en_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [EW-1:0] e;
        logic [31:0] outs_b[6];

        {ifa.pc_i, ifa.instr_i, ifa.out_i} = '0;
        {ifb.pc_i, ifb.instr_i, ifb.out_i} = '0;
        ifa.arm_i = 0; ifa.trig_en_i = 0; ifa.trig_pc_i = '0; ifa.post_cnt_i = '0; ifa.rd_en_i = 0;
        ifb.arm_i = 0; ifb.trig_en_i = 0; ifb.trig_pc_i = '0; ifb.post_cnt_i = '0; ifb.rd_en_i = 0;

        tv[0]  = '{0,  2'd1, 1, 1'b0};
        tv[1]  = '{1,  2'd1, 2, 1'b0};
        tv[2]  = '{2,  2'd1, 3, 1'b0};
        tv[3]  = '{3,  2'd1, 4, 1'b0};
        tv[4]  = '{4,  2'd1, 5, 1'b0};
        tv[5]  = '{5,  2'd1, 6, 1'b0};
        tv[6]  = '{6,  2'd1, 7, 1'b0};
        tv[7]  = '{7,  2'd1, 8, 1'b0};
        tv[8]  = '{8,  2'd2, 8, 1'b1};
        tv[9]  = '{9,  2'd2, 8, 1'b1};
        tv[10] = '{10, 2'd2, 8, 1'b1};
        tv[11] = '{11, 2'd3, 8, 1'b1};

        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst state", ifa.state_o, 2'd0);
        chk("rst count", ifa.count_o, 0);
        chk("rst empty", ifa.rd_empty_o, 1'b1);
        chk("rst valid", ifa.rd_valid_o, 1'b0);
        chk("rst trig", ifa.triggered_o, 1'b0);
        chk("rst data", ifa.rd_data_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Trigger at PC 0x20 with post window 3
        ifa.trig_en_i = 1'b1;
        ifa.trig_pc_i = 32'h20;
        arm_a(3'd3);
        chk("arm state", ifa.state_o, 2'd1);
        chk("arm count", ifa.count_o, 0);
        for (int k = 0; k < 12; k++) begin
            drv_a(tv[k].idx);
            push_a(tv[k].idx);
            tick;
            chk($sformatf("vec%0d state", k), ifa.state_o, tv[k].st);
            chk($sformatf("vec%0d count", k), ifa.count_o, tv[k].cnt);
            chk($sformatf("vec%0d trig", k), ifa.triggered_o, tv[k].trg);
        end
        ifa.trig_en_i = 1'b0;
        drv_a(12);
        tick;
        chk("done no write", ifa.count_o, 8);
        e = sb_a[0];
        chk("oldest pc 0x10", e, smp(4));
        pop_all_a("main pop", 12, pulses);
        chk("main pulses", pulses, 8);
        chk("main empty", ifa.rd_empty_o, 1'b1);
        chk("main count0", ifa.count_o, 0);
        chk("data hold", ifa.rd_data_o, smp(11));

        // Reads ignored when empty and during PRE
        ifa.rd_en_i = 1'b1;
        tick;
        chk("empty rd valid", ifa.rd_valid_o, 1'b0);
        arm_a(3'd0);
        for (int k = 0; k < 2; k++) begin
            drv_a(50 + k);
            tick;
            chk("pre rd valid", ifa.rd_valid_o, 1'b0);
            chk("pre rd count", ifa.count_o, k + 1);
        end
        ifa.rd_en_i = 1'b0;

        // Free-running wrap then stop with post_cnt 0
        arm_a(3'd0);
        for (int j = 100; j < 120; j++) begin
            drv_a(j);
            push_a(j);
            tick;
        end
        chk("wrap count", ifa.count_o, 8);
        chk("wrap state", ifa.state_o, 2'd1);
        e = smp(120);
        ifa.trig_pc_i = e[95:64];
        ifa.trig_en_i = 1'b1;
        drv_a(120);
        push_a(120);
        tick;
        ifa.trig_en_i = 1'b0;
        chk("wrap done", ifa.state_o, 2'd3);
        chk("wrap done count", ifa.count_o, 8);
        ifa.rd_en_i = 1'b1;
        tick;
        chk("wrap oldest", ifa.rd_data_o, smp(113));
        void'(sb_a.pop_front());
        pop_all_a("wrap pop", 10, pulses);
        chk("wrap pulses", pulses, 7);

        // Maximum post window (7 for DEPTH 8), then re-arm with 5 entries left
        e = smp(200);
        ifa.trig_pc_i = e[95:64];
        ifa.trig_en_i = 1'b1;
        arm_a(3'd7);
        drv_a(200);
        push_a(200);
        tick;
        chk("max post trig", ifa.state_o, 2'd2);
        for (int j = 201; j < 207; j++) begin
            drv_a(j);
            push_a(j);
            tick;
        end
        chk("max post still", ifa.state_o, 2'd2);
        drv_a(207);
        push_a(207);
        tick;
        chk("max post done", ifa.state_o, 2'd3);
        ifa.trig_en_i = 1'b0;
        ifa.rd_en_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("partial pop", ifa.rd_data_o, sb_a.pop_front());
        end
        ifa.rd_en_i = 1'b0;
        chk("five left", ifa.count_o, 5);
        ifa.arm_i = 1'b1;
        tick;
        ifa.arm_i = 1'b0;
        chk("rearm count", ifa.count_o, 0);
        chk("rearm trig", ifa.triggered_o, 1'b0);
        chk("rearm state", ifa.state_o, 2'd1);

        // Change-only capture on the MODE 1 instance
        outs_b[0] = 4; outs_b[1] = 4; outs_b[2] = 4;
        outs_b[3] = 5; outs_b[4] = 5; outs_b[5] = 9;
        ifb.trig_en_i  = 1'b1;
        ifb.trig_pc_i  = 32'h54;
        ifb.post_cnt_i = '0;
        ifb.arm_i      = 1'b1;
        tick;
        ifb.arm_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ifb.pc_i    = 32'h40 + 32'(4 * k);
            ifb.instr_i = 32'(k);
            ifb.out_i   = outs_b[k];
            if (k == 0 || k == 3 || k == 5) sb_b.push_back({ifb.pc_i, ifb.instr_i, ifb.out_i});
            tick;
        end
        chk("m1 state", ifb.state_o, 2'd3);
        chk("m1 count", ifb.count_o, 3);
        chk("m1 trig", ifb.triggered_o, 1'b1);
        pulses = 0;
        ifb.rd_en_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (ifb.rd_valid_o) begin
                pulses++;
                if (sb_b.size() > 0) chk("m1 pop", ifb.rd_data_o, sb_b.pop_front());
                else chk("m1 extra pop", ifb.rd_valid_o, 1'b0);
            end
        end
        ifb.rd_en_i = 1'b0;
        chk("m1 pulses", pulses, 3);
        chk("m1 empty", ifb.rd_empty_o, 1'b1);

        // Asynchronous reset in the middle of a post window
        e = smp(300);
        ifa.trig_pc_i = e[95:64];
        ifa.trig_en_i = 1'b1;
        arm_a(3'd5);
        drv_a(300);
        tick;
        drv_a(301);
        tick;
        chk("pre-rst post", ifa.state_o, 2'd2);
        chk("pre-rst count", ifa.count_o, 2);
        #1 rst = 1'b1;
        #1;
        chk("async rst state", ifa.state_o, 2'd0);
        chk("async rst count", ifa.count_o, 0);
        chk("async rst empty", ifa.rd_empty_o, 1'b1);
        chk("async rst valid", ifa.rd_valid_o, 1'b0);
        chk("async rst trig", ifa.triggered_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
